// File: rtl/servant_uart_rx.sv
// rtl/servant_uart_rx.sv - 8N1 UART receiver with byte FIFO and valid/ready output
// Optional macro SERVANT_UART_PARITY_EN adds an even-parity bit between data and stop.
module servant_uart_rx #(
  parameter int CLK_FREQ   = 32000000,
  parameter int BAUD       = 57600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic                        i_rx,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_frame_err,
  output logic                        o_overflow,
  output logic                        o_parity_err,
  input  logic                        i_clr
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

`ifdef SERVANT_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bitn, bitn_n;
  logic          rx_meta, rxs, rxs_d;
  logic          fall, expire;
  logic          push_req, ferr_set;
`ifdef SERVANT_UART_PARITY_EN
  logic          par_bad, par_bad_n, perr_set;
`endif

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, pop, push, ovf_set;

  // Synchroniser resets high so the line reads idle out of reset
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign fall   = rxs_d & ~rxs;
  assign expire = (cnt == CW'(1));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bitn    <= '0;
`ifdef SERVANT_UART_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      bitn    <= bitn_n;
`ifdef SERVANT_UART_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bitn_n    = bitn;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
`ifdef SERVANT_UART_PARITY_EN
    par_bad_n = par_bad;
    perr_set  = 1'b0;
`endif
    if (state != IDLE && !expire) cnt_n = cnt - CW'(1);
    case (state)
      IDLE: begin
        // Only a fresh falling edge starts a frame, so a held break is ignored
        if (fall) begin
          state_n = START;
          cnt_n   = CW'(CPB / 2);
`ifdef SERVANT_UART_PARITY_EN
          par_bad_n = 1'b0;
`endif
        end
      end
      START: begin
        if (expire) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            cnt_n   = CW'(CPB);
            bitn_n  = '0;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shreg_n = {rxs, shreg[7:1]};
          cnt_n   = CW'(CPB);
          bitn_n  = bitn + 3'd1;
          if (bitn == 3'd7) begin
`ifdef SERVANT_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef SERVANT_UART_PARITY_EN
      PARITY: begin
        if (expire) begin
          state_n = STOP;
          cnt_n   = CW'(CPB);
          if (rxs != ^shreg) begin
            perr_set  = 1'b1;
            par_bad_n = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (expire) begin
          state_n = IDLE;
          if (rxs) begin
`ifdef SERVANT_UART_PARITY_EN
            push_req = ~par_bad;
`else
            push_req = 1'b1;
`endif
          end else begin
            ferr_set = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_level = wptr - rptr;
  assign o_valid = (o_level != '0);
  assign full    = (o_level == (AW + 1)'(FIFO_DEPTH));
  assign pop     = o_valid & i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push    = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;
  assign o_data  = o_valid ? mem[rptr[AW-1:0]] : 8'h00;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW + 1)'(1);
      if (pop)  rptr <= rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (ferr_set)   o_frame_err <= 1'b1;
      else if (i_clr) o_frame_err <= 1'b0;
      if (ovf_set)    o_overflow  <= 1'b1;
      else if (i_clr) o_overflow  <= 1'b0;
    end
  end

`ifdef SERVANT_UART_PARITY_EN
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)        o_parity_err <= 1'b0;
    else if (perr_set) o_parity_err <= 1'b1;
    else if (i_clr)    o_parity_err <= 1'b0;
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
